// File: rtl/axi4_lite_cmd_master.sv
// axi4_lite_cmd_master: turns a single-beat command stream into AXI4-Lite
// write/read transactions, one at a time, and returns the response on a
// valid/ready port. All outputs are registered.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to build the cycle counter
// and sticky TIMEOUT flag; otherwise TIMEOUT is tied low.
module axi4_lite_cmd_master #(
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = 32'h7c800000,
  parameter int                            C_OFFSET_WIDTH     = 16,
  parameter int                            C_TIMEOUT          = 8
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  // command stream
  input  logic                          CMD_VALID,
  output logic                          CMD_READY,
  input  logic                          CMD_WRITE,
  input  logic [C_OFFSET_WIDTH-1:0]     CMD_OFFSET,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] CMD_WDATA,
  // response stream
  output logic                          RSP_VALID,
  input  logic                          RSP_READY,
  output logic                          RSP_WRITE,
  output logic [C_S_AXI_DATA_WIDTH-1:0] RSP_RDATA,
  output logic [1:0]                    RSP_RESP,
  output logic                          BUSY,
  output logic                          TIMEOUT,
  // AXI4-Lite master
  output logic [C_S_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;

  // Only a 32-bit data path and an 8-bit watchdog are implemented.
  if (DW != 32 || C_TIMEOUT < 1 || C_TIMEOUT > 255 || C_OFFSET_WIDTH >= AW) begin : g_param_err
    $error("axi4_lite_cmd_master: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_RESP
  } state_t;

  state_t          state_q;
  logic            cmd_ready_q, busy_q;
  logic            rsp_valid_q, rsp_write_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic [1:0]      rsp_resp_q;
  logic [AW-1:0]   awaddr_q, araddr_q;
  logic [DW-1:0]   wdata_q;
  logic            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

  // Word-aligned target address of the incoming command.
  logic [AW-1:0]   addr_sum;
  logic [AW-1:0]   addr_d;
  assign addr_sum = C_BASEADDR + {{(AW-C_OFFSET_WIDTH){1'b0}}, CMD_OFFSET};
  assign addr_d   = {addr_sum[AW-1:2], 2'b00};

  // Handshake completion terms for the write-address/data phase.
  logic aw_done, w_done;
  assign aw_done = !awvalid_q || M_AXI_AWREADY;
  assign w_done  = !wvalid_q  || M_AXI_WREADY;

  // Transaction FSM; every output is a register updated on the transition.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (CMD_VALID) begin
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          rsp_write_q <= CMD_WRITE;
          if (CMD_WRITE) begin
            awaddr_q  <= addr_d;
            wdata_q   <= CMD_WDATA;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= S_WRITE;
          end else begin
            araddr_q  <= addr_d;
            arvalid_q <= 1'b1;
            state_q   <= S_RADDR;
          end
        end
        S_WRITE: begin
          // AW and W retire independently; move on once both have.
          if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q  && M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: if (M_AXI_BVALID) begin
          bready_q    <= 1'b0;
          rsp_resp_q  <= M_AXI_BRESP;
          rsp_rdata_q <= '0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RADDR: if (M_AXI_ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= S_RDATA;
        end
        S_RDATA: if (M_AXI_RVALID) begin
          rready_q    <= 1'b0;
          rsp_rdata_q <= M_AXI_RDATA;
          rsp_resp_q  <= M_AXI_RRESP;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: if (RSP_READY) begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  logic [7:0] to_cnt_q;
  logic       timeout_q;
  logic       in_xfer;
  assign in_xfer = (state_q == S_WRITE) || (state_q == S_WRESP) ||
                   (state_q == S_RADDR) || (state_q == S_RDATA);

  // Watchdog: counts cycles of the current transaction; flag is sticky
  // and purely informational, the transaction keeps running.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      to_cnt_q  <= 8'd0;
      timeout_q <= 1'b0;
    end else if (state_q == S_IDLE && CMD_VALID) begin
      to_cnt_q  <= 8'd0;
    end else if (in_xfer) begin
      if (to_cnt_q != 8'hFF) to_cnt_q <= to_cnt_q + 8'd1;
      if (int'(to_cnt_q) + 1 >= C_TIMEOUT) timeout_q <= 1'b1;
    end
  end
  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

  assign CMD_READY     = cmd_ready_q;
  assign BUSY          = busy_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_WRITE     = rsp_write_q;
  assign RSP_RDATA     = rsp_rdata_q;
  assign RSP_RESP      = rsp_resp_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Directed bench for axi4_lite_cmd_master; the AXI slave side is driven by
// hand, cycle by cycle. Cycle 0 is the cycle in which a command is accepted.
module tb_axi4_lite_cmd_master;

  logic        M_AXI_ACLK, M_AXI_ARESET;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [15:0] CMD_OFFSET;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID, RSP_READY, RSP_WRITE;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;
  logic        BUSY, TIMEOUT;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  int n_chk  = 0;
  int n_fail = 0;

  axi4_lite_cmd_master dut (
    .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESET(M_AXI_ARESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_OFFSET(CMD_OFFSET), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
    .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP), .BUSY(BUSY), .TIMEOUT(TIMEOUT),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial M_AXI_ACLK = 1'b0;
  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic tick();
    @(negedge M_AXI_ACLK);
  endtask

  // Presents one command in cycle 0 and advances to cycle 1.
  task automatic issue(input logic wr, input logic [15:0] off, input logic [31:0] wd);
    chk("cmd_ready_c0", {31'd0, CMD_READY}, 32'd1);
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_OFFSET = off; CMD_WDATA = wd;
    tick();
    CMD_VALID = 1'b0;
  endtask

  // AXI valid/ready outputs packed {AWV,WV,BR,ARV,RR}.
  function automatic logic [31:0] axi_act();
    return {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY};
  endfunction

  initial begin
    M_AXI_ARESET = 1'b1;
    CMD_VALID = 0; CMD_WRITE = 0; CMD_OFFSET = '0; CMD_WDATA = '0; RSP_READY = 0;
    M_AXI_AWREADY = 1; M_AXI_WREADY = 1; M_AXI_ARREADY = 1;
    M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RRESP = 0;
    tick(); tick();
    // reset values
    chk("rst_cmd_ready", {31'd0, CMD_READY}, 32'd1);
    chk("rst_axi_act",   axi_act(), 32'd0);
    chk("rst_rsp",       {29'd0, RSP_VALID, RSP_WRITE, BUSY}, 32'd0);
    chk("rst_rdata",     RSP_RDATA, 32'd0);
    chk("rst_resp",      {30'd0, RSP_RESP}, 32'd0);
    chk("rst_awaddr",    M_AXI_AWADDR, 32'd0);
    chk("rst_araddr",    M_AXI_ARADDR, 32'd0);
    chk("rst_wdata",     M_AXI_WDATA, 32'd0);
    chk("rst_timeout",   {31'd0, TIMEOUT}, 32'd0);
    M_AXI_ARESET = 1'b0;
    tick();

    // ---- write, zero-wait slave ----
    issue(1'b1, 16'h0004, 32'h0000_0005);
    chk("w1_c1_act",    axi_act(), 32'b11000);
    chk("w1_awaddr",    M_AXI_AWADDR, 32'h7c80_0004);
    chk("w1_wdata",     M_AXI_WDATA, 32'h5);
    chk("w1_wstrb",     {28'd0, M_AXI_WSTRB}, 32'hF);
    chk("w1_c1_cmdrdy", {31'd0, CMD_READY}, 32'd0);
    chk("w1_c1_busy",   {31'd0, BUSY}, 32'd1);
    tick();
    chk("w1_c2_act",    axi_act(), 32'b00100);
    M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
    tick();
    M_AXI_BVALID = 0;
    chk("w1_c3_rspv",   {31'd0, RSP_VALID}, 32'd1);
    chk("w1_c3_rspw",   {31'd0, RSP_WRITE}, 32'd1);
    chk("w1_c3_resp",   {30'd0, RSP_RESP}, 32'd0);
    chk("w1_c3_rdata",  RSP_RDATA, 32'd0);
    chk("w1_c3_act",    axi_act(), 32'd0);
    RSP_READY = 1;
    tick();
    RSP_READY = 0;
    chk("w1_c4_rspv",   {31'd0, RSP_VALID}, 32'd0);
    chk("w1_c4_cmdrdy", {31'd0, CMD_READY}, 32'd1);
    chk("w1_c4_busy",   {31'd0, BUSY}, 32'd0);

    // ---- read, RVALID delayed 3 cycles; offset low bits dropped ----
    issue(1'b0, 16'h0013, 32'h0);
    chk("r1_c1_act",    axi_act(), 32'b00010);
    chk("r1_araddr",    M_AXI_ARADDR, 32'h7c80_0010);
    tick();
    for (int c = 2; c <= 5; c++) begin
      chk("r1_rready", axi_act(), 32'b00001);
      chk("r1_norsp",  {31'd0, RSP_VALID}, 32'd0);
      if (c == 5) begin M_AXI_RVALID = 1; M_AXI_RDATA = 32'h20; M_AXI_RRESP = 2'b00; end
      tick();
    end
    M_AXI_RVALID = 0; M_AXI_RDATA = 32'hFFFF_FFFF;
    chk("r1_rspv",  {31'd0, RSP_VALID}, 32'd1);
    chk("r1_rdata", RSP_RDATA, 32'h20);
    chk("r1_rspw",  {31'd0, RSP_WRITE}, 32'd0);
    chk("r1_resp",  {30'd0, RSP_RESP}, 32'd0);
    chk("r1_act",   axi_act(), 32'd0);
    RSP_READY = 1;
    tick();
    RSP_READY = 0;

    // ---- AW in cycle 1, WREADY late; then RSP_READY held off ----
    M_AXI_WREADY = 0;
    issue(1'b1, 16'h0100, 32'hCAFE_0001);
    chk("w2_c1_act", axi_act(), 32'b11000);
    tick();
    chk("w2_c2_act",   axi_act(), 32'b01000);
    chk("w2_c2_wdata", M_AXI_WDATA, 32'hCAFE_0001);
    tick();
    chk("w2_c3_act",   axi_act(), 32'b01000);
    chk("w2_c3_wdata", M_AXI_WDATA, 32'hCAFE_0001);
    chk("w2_awaddr",   M_AXI_AWADDR, 32'h7c80_0100);
    M_AXI_WREADY = 1;
    tick();
    chk("w2_c4_act", axi_act(), 32'b00100);
    M_AXI_BVALID = 1; M_AXI_BRESP = 2'b10;
    tick();
    M_AXI_BVALID = 0;
    // queue a read that must wait for the response handshake
    CMD_VALID = 1; CMD_WRITE = 0; CMD_OFFSET = 16'h0008;
    for (int c = 5; c <= 9; c++) begin
      chk("w2_hold_rspv", {31'd0, RSP_VALID}, 32'd1);
      chk("w2_hold_resp", {30'd0, RSP_RESP}, 32'd2);
      chk("w2_hold_rspw", {31'd0, RSP_WRITE}, 32'd1);
      chk("w2_hold_cmdr", {31'd0, CMD_READY}, 32'd0);
      chk("w2_hold_act",  axi_act(), 32'd0);
      if (c == 9) RSP_READY = 1;
      tick();
    end
    RSP_READY = 0;
    chk("q_c0_cmdrdy", {31'd0, CMD_READY}, 32'd1);
    chk("q_c0_rspv",   {31'd0, RSP_VALID}, 32'd0);
    tick();
    CMD_VALID = 0;
    chk("q_c1_act",    axi_act(), 32'b00010);
    chk("q_araddr",    M_AXI_ARADDR, 32'h7c80_0008);
    tick();
    chk("q_c2_act",    axi_act(), 32'b00001);
    M_AXI_RVALID = 1; M_AXI_RDATA = 32'hDEAD_BEEF; M_AXI_RRESP = 2'b01;
    tick();
    M_AXI_RVALID = 0;
    chk("q_c3_rspv",   {31'd0, RSP_VALID}, 32'd1);
    chk("q_rdata",     RSP_RDATA, 32'hDEAD_BEEF);
    chk("q_resp",      {30'd0, RSP_RESP}, 32'd1);
    RSP_READY = 1;
    tick();
    RSP_READY = 0;

    // ---- reset while in RDATA ----
    issue(1'b0, 16'h0020, 32'h0);
    tick();
    chk("rr_c2_rready", axi_act(), 32'b00001);
    #2 M_AXI_ARESET = 1'b1;
    #1;
    chk("rr_act",    axi_act(), 32'd0);
    chk("rr_busy",   {31'd0, BUSY}, 32'd0);
    chk("rr_rspv",   {31'd0, RSP_VALID}, 32'd0);
    chk("rr_cmdrdy", {31'd0, CMD_READY}, 32'd1);
    tick();
    M_AXI_ARESET = 1'b0;
    tick();
    issue(1'b1, 16'h0004, 32'h0000_00A5);
    chk("rr_w_c1_act", axi_act(), 32'b11000);
    chk("rr_w_wdata",  M_AXI_WDATA, 32'hA5);
    tick();
    M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
    tick();
    M_AXI_BVALID = 0;
    chk("rr_w_c3_rspv", {31'd0, RSP_VALID}, 32'd1);
    chk("rr_w_rspw",    {31'd0, RSP_WRITE}, 32'd1);
    RSP_READY = 1;
    tick();
    RSP_READY = 0;
    chk("rr_w_idle",    {31'd0, CMD_READY}, 32'd1);

`ifdef AXI_MASTER_TIMEOUT_EN
    // ---- watchdog: AWREADY low 20 cycles ----
    M_AXI_AWREADY = 0;
    issue(1'b1, 16'h0040, 32'h77);
    for (int c = 1; c <= 20; c++) begin
      chk("to_flag", {31'd0, TIMEOUT}, (c >= 9) ? 32'd1 : 32'd0);
      tick();
    end
    M_AXI_AWREADY = 1;
    tick();
    M_AXI_BVALID = 1;
    tick();
    M_AXI_BVALID = 0;
    chk("to_rspv", {31'd0, RSP_VALID}, 32'd1);
    RSP_READY = 1;
    tick();
    RSP_READY = 0;
    chk("to_sticky", {31'd0, TIMEOUT}, 32'd1);
    chk("to_idle",   {31'd0, BUSY}, 32'd0);
`else
    chk("timeout_tied", {31'd0, TIMEOUT}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_lite_cmd_master.md
# axi4_lite_cmd_master

- Upstream AXI4-Lite master that converts a simple single-beat command stream into AXI4-Lite write and read transactions.
- Drives the exponent/multiplier AXI4-Lite slave IP at `C_BASEADDR`.
- Returns each transaction's response and read data on a valid/ready response port.
- Used by the in-fabric sequencer and by the system bench as the bus driver in place of a CPU.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 32, AXI address width.
- C_BASEADDR, 32'h7c800000, base address added to every command offset.
- C_OFFSET_WIDTH, 16, width of the command byte offset.
- C_TIMEOUT, 8, watchdog limit in cycles; used only with `AXI_MASTER_TIMEOUT_EN`.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESET  in  1  asynchronous reset, active-high.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  command accepted this cycle when high together with CMD_VALID.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_OFFSET  in  C_OFFSET_WIDTH  byte offset from C_BASEADDR.
- CMD_WDATA  in  32  write data.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response consumed.
- RSP_WRITE  out  1  echoes CMD_WRITE of the completed command.
- RSP_RDATA  out  32  read data; 0 for writes.
- RSP_RESP  out  2  BRESP or RRESP from the slave.
- BUSY  out  1  high whenever not in IDLE.
- TIMEOUT  out  1  sticky watchdog flag; tied to 0 when the macro is absent.
- M_AXI_AWADDR  out  32  write address.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WSTRB  out  4  write strobes.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- M_AXI_ARADDR  out  32  read address.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  32  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.

## Operation
- States: IDLE, WRITE, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID, latch the command.
  - Address = C_BASEADDR + zero-extended CMD_OFFSET, with bits [1:0] forced to 0.
  - Go to WRITE if CMD_WRITE, else RADDR.
- WRITE:
  - AWVALID and WVALID are asserted together.
  - Each is cleared independently on its own handshake.
  - Leave for WRESP when both handshakes are done, in either order or in the same cycle.
- WRESP: BREADY=1. On BVALID, capture BRESP, set RDATA=0, go to RESP.
- RADDR: ARVALID=1 until ARREADY, then go to RDATA.
- RDATA: RREADY=1. On RVALID, capture RDATA and RRESP, go to RESP.
- RESP: RSP_VALID=1 with stable payload. On RSP_READY, go to IDLE.
- Exactly one transaction is outstanding at a time. No pipelining of commands.
- WSTRB is constant 4'hF. AWADDR, WDATA and ARADDR hold stable while their VALID is high.
- A VALID is never deasserted before its handshake.

## Timing
- All outputs are registered.
- Reset values:
  - All VALID and READY outputs 0, except CMD_READY=1.
  - RSP_RDATA=0, RSP_RESP=0, RSP_WRITE=0, addresses and WDATA=0, BUSY=0, TIMEOUT=0, state IDLE.
- Latency is measured from the command accept edge (cycle 0).
  - VALIDs rise in cycle 1.
  - Against a zero-wait slave (READYs high, BVALID/RVALID in the cycle after the address handshake), RSP_VALID rises in cycle 3.
  - Throughput: one command per 4 cycles minimum.
- CMD_READY is 0 from cycle 1 until the cycle after the RSP_READY handshake.
- M_AXI_ARESET asserted mid-transaction:
  - All outputs take their reset values immediately.
  - The latched command and any pending response are discarded.
  - The slave is expected to be reset by the same event.
- BVALID or RVALID arriving outside WRESP/RDATA is ignored: READY is low, so the slave must hold it.

## Configuration
- `AXI_MASTER_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WRITE or RADDR.
  - It increments every cycle the state is WRITE, WRESP, RADDR or RDATA.
  - On reaching C_TIMEOUT, TIMEOUT sets and stays set until reset.
  - The transaction is not aborted; the protocol stays legal.
- Undefined: no counter is built and TIMEOUT is tied to 0.

## Test plan
- Write, zero-wait slave: offset 0x0004, data 0x00000005 -> AWADDR 0x7c800004, WDATA 0x5, WSTRB 0xF; RSP_VALID in cycle 3, RSP_RESP 00, RSP_WRITE 1.
- Read, RVALID delayed 3 cycles, RDATA 0x00000020 -> RREADY held high 4 cycles; RSP_RDATA 0x20, RSP_WRITE 0, RSP_RESP 00.
- AW accepted cycle 1, WREADY delayed to cycle 3 -> AWVALID drops after cycle 1, WVALID held through cycle 3, WDATA stable, single BREADY phase.
- RSP_READY held low 5 cycles -> RSP payload stable, CMD_READY 0, no AXI activity; a second queued command starts the cycle after the handshake.
- Reset asserted while in RDATA -> RREADY, RSP_VALID and BUSY drop the same cycle, CMD_READY 1; the next command completes normally.
- With `AXI_MASTER_TIMEOUT_EN`, C_TIMEOUT=8, AWREADY held low 20 cycles -> TIMEOUT rises on cycle 8 after entry and stays 1 after the write completes.
